// File: rtl/dispatch_credit_ctrl_pkg.sv
// Shared types and constants for the 3-wide dispatch credit controller.
package dispatch_credit_ctrl_pkg;

    typedef enum logic [1:0] {
        DC_RUN     = 2'd0,
        DC_RECOVER = 2'd1,
        DC_HALT    = 2'd2
    } disp_ctrl_state_e;

    localparam int SYS_PR_FREE_INIT = 32;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/dispatch_credit_ctrl_credit_counter.sv
// One free-entry credit counter: consume on dispatch, release on drain, bulk load on squash.
module dispatch_credit_ctrl_credit_counter #(
    parameter  int MAX = 32,
    localparam int CW  = $clog2(MAX + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [1:0]    consume_i,
    input  logic [1:0]    release_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic [CW-1:0] count_o
);

    localparam int SW = CW + 1;

    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] sum;

    // One extra bit makes both underflow (wraps high) and overflow land above MAX.
    always_comb begin
        sum     = {1'b0, count_q} + SW'(release_i) - SW'(consume_i);
        count_d = load_i ? load_val_i : sum[CW-1:0];
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= CW'(MAX);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

    credit_in_range: assert property (@(posedge clock) disable iff (!reset_n)
        load_i || (sum <= SW'(MAX)));

endmodule

// File: rtl/dispatch_credit_ctrl.sv
// Credit-based dispatch scheduler: in-order stall mask, squash recovery and halt freeze.
module dispatch_credit_ctrl
    import dispatch_credit_ctrl_pkg::*;
#(
    parameter  int ROB_SIZE     = 32,
    parameter  int RS_SIZE      = 16,
    parameter  int SQ_SIZE      = 8,
    parameter  int PR_FREE_INIT = SYS_PR_FREE_INIT,
    localparam int CW_ROB       = $clog2(ROB_SIZE + 1),
    localparam int CW_RS        = $clog2(RS_SIZE + 1),
    localparam int CW_SQ        = $clog2(SQ_SIZE + 1),
    localparam int CW_PR        = $clog2(PR_FREE_INIT + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [2:0]        req_valid_i,
    input  logic [2:0]        req_needs_pr_i,
    input  logic [2:0]        req_is_store_i,
    input  logic [2:0]        req_is_halt_i,
    input  logic [1:0]        rob_retire_cnt_i,
    input  logic [1:0]        rs_issue_cnt_i,
    input  logic [1:0]        sq_retire_cnt_i,
    input  logic [1:0]        fl_return_cnt_i,
    input  logic              squash_i,
    input  logic [CW_PR-1:0]  fl_recover_cnt_i,
    output logic [2:0]        dispatch_stall_mask_o,
    output logic [2:0]        dispatch_fire_o,
    output logic [CW_ROB-1:0] rob_credits_o,
    output logic [CW_RS-1:0]  rs_credits_o,
    output logic [CW_SQ-1:0]  sq_credits_o,
    output logic [CW_PR-1:0]  pr_credits_o,
    output disp_ctrl_state_e  ctrl_state_o
);

    disp_ctrl_state_e state_q, state_d;

    logic [2:0] stall_mask;
    logic [2:0] fire;
    logic       blocked;
    logic [1:0] cum_slot, cum_pr, cum_sq;

    // Walk oldest (slot 2) to youngest; once a slot blocks, all younger slots block too.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        stall_mask = 3'b111;
        blocked    = 1'b0;
        cum_slot   = '0;
        cum_pr     = '0;
        cum_sq     = '0;
        if (reset_n && !squash_i && state_q == DC_RUN) begin
            for (int i = 2; i >= 0; i--) begin
                if (req_valid_i[i] && !blocked) begin
                    cum_slot = cum_slot + 2'd1;
                    cum_pr   = cum_pr + 2'(req_needs_pr_i[i]);
                    cum_sq   = cum_sq + 2'(req_is_store_i[i]);
                    if (CW_ROB'(cum_slot) > rob_credits_o ||
                        CW_RS'(cum_slot)  > rs_credits_o  ||
                        CW_PR'(cum_pr)    > pr_credits_o  ||
                        CW_SQ'(cum_sq)    > sq_credits_o) begin
                        blocked = 1'b1;
                    end
                end
                stall_mask[i] = blocked;
                if (req_valid_i[i] && req_is_halt_i[i]) begin
                    blocked = 1'b1;
                end
            end
        end
    end

    assign fire                  = req_valid_i & ~stall_mask;
    assign dispatch_stall_mask_o = stall_mask;
    assign dispatch_fire_o       = fire;

    dispatch_credit_ctrl_credit_counter #(.MAX(ROB_SIZE)) u_rob_credit (
        .clock      (clock),
        .reset_n    (reset_n),
        .consume_i  (popcount3(fire)),
        .release_i  (rob_retire_cnt_i),
        .load_i     (squash_i),
        .load_val_i (CW_ROB'(ROB_SIZE)),
        .count_o    (rob_credits_o)
    );

    dispatch_credit_ctrl_credit_counter #(.MAX(RS_SIZE)) u_rs_credit (
        .clock      (clock),
        .reset_n    (reset_n),
        .consume_i  (popcount3(fire)),
        .release_i  (rs_issue_cnt_i),
        .load_i     (squash_i),
        .load_val_i (CW_RS'(RS_SIZE)),
        .count_o    (rs_credits_o)
    );

    dispatch_credit_ctrl_credit_counter #(.MAX(SQ_SIZE)) u_sq_credit (
        .clock      (clock),
        .reset_n    (reset_n),
        .consume_i  (popcount3(fire & req_is_store_i)),
        .release_i  (sq_retire_cnt_i),
        .load_i     (squash_i),
        .load_val_i (CW_SQ'(SQ_SIZE)),
        .count_o    (sq_credits_o)
    );

    // After a squash the free list reports its own recovered occupancy.
    dispatch_credit_ctrl_credit_counter #(.MAX(PR_FREE_INIT)) u_pr_credit (
        .clock      (clock),
        .reset_n    (reset_n),
        .consume_i  (popcount3(fire & req_needs_pr_i)),
        .release_i  (fl_return_cnt_i),
        .load_i     (squash_i),
        .load_val_i (fl_recover_cnt_i),
        .count_o    (pr_credits_o)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DC_RUN: begin
                if (squash_i) begin
                    state_d = DC_RECOVER;
                end else if (|(fire & req_is_halt_i)) begin
                    state_d = DC_HALT;
                end
            end
            DC_RECOVER: state_d = squash_i ? DC_RECOVER : DC_RUN;
            DC_HALT:    state_d = squash_i ? DC_RECOVER : DC_HALT;
            default:    state_d = DC_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= DC_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign ctrl_state_o = state_q;

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// Self-checking bench: directed vector table, hand sequences, then random against a model.
module tb_dispatch_credit_ctrl;
    import dispatch_credit_ctrl_pkg::*;

    localparam int ROB_SIZE = 32;
    localparam int RS_SIZE  = 16;
    localparam int SQ_SIZE  = 8;
    localparam int PR_INIT  = 32;

    logic             clock;
    logic             reset_n;
    logic [2:0]       req_valid, req_needs_pr, req_is_store, req_is_halt;
    logic [1:0]       rob_rel, rs_rel, sq_rel, fl_rel;
    logic             squash;
    logic [5:0]       fl_recover;
    logic [2:0]       stall_mask, fire;
    logic [5:0]       rob_cr;
    logic [4:0]       rs_cr;
    logic [3:0]       sq_cr;
    logic [5:0]       pr_cr;
    disp_ctrl_state_e state;

    dispatch_credit_ctrl dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .req_valid_i           (req_valid),
        .req_needs_pr_i        (req_needs_pr),
        .req_is_store_i        (req_is_store),
        .req_is_halt_i         (req_is_halt),
        .rob_retire_cnt_i      (rob_rel),
        .rs_issue_cnt_i        (rs_rel),
        .sq_retire_cnt_i       (sq_rel),
        .fl_return_cnt_i       (fl_rel),
        .squash_i              (squash),
        .fl_recover_cnt_i      (fl_recover),
        .dispatch_stall_mask_o (stall_mask),
        .dispatch_fire_o       (fire),
        .rob_credits_o         (rob_cr),
        .rs_credits_o          (rs_cr),
        .sq_credits_o          (sq_cr),
        .pr_credits_o          (pr_cr),
        .ctrl_state_o          (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    typedef struct {
        logic             rst_n;
        logic [2:0]       valid, needs_pr, is_store, is_halt;
        logic [1:0]       rob_rel, rs_rel, sq_rel, fl_rel;
        logic             squash;
        logic [5:0]       fl_rec;
        logic [2:0]       exp_mask, exp_fire;
        int               exp_rob, exp_rs, exp_sq, exp_pr;
        disp_ctrl_state_e exp_state;
    } vec_t;

    // Drive one cycle of inputs, check the combinational outputs mid-cycle,
    // then check credits/state just after the edge.
    task automatic apply_vec(input vec_t v, input string tag);
        reset_n      = v.rst_n;
        req_valid    = v.valid;
        req_needs_pr = v.needs_pr;
        req_is_store = v.is_store;
        req_is_halt  = v.is_halt;
        rob_rel      = v.rob_rel;
        rs_rel       = v.rs_rel;
        sq_rel       = v.sq_rel;
        fl_rel       = v.fl_rel;
        squash       = v.squash;
        fl_recover   = v.fl_rec;
        #4;
        check({tag, ".mask"}, int'(stall_mask), int'(v.exp_mask));
        check({tag, ".fire"}, int'(fire), int'(v.exp_fire));
        @(posedge clock);
        #1;
        check({tag, ".rob"}, int'(rob_cr), v.exp_rob);
        check({tag, ".rs"}, int'(rs_cr), v.exp_rs);
        check({tag, ".sq"}, int'(sq_cr), v.exp_sq);
        check({tag, ".pr"}, int'(pr_cr), v.exp_pr);
        check({tag, ".state"}, int'(state), int'(v.exp_state));
    endtask

    // Reference model: credit pools as integers, grant the longest oldest-first prefix.
    int               m_rob, m_rs, m_sq, m_pr;
    disp_ctrl_state_e m_state;
    bit               m_known = 1'b0;

    task automatic model_outputs(output logic [2:0] e_mask, output logic [2:0] e_fire);
        int best;
        bit ok;
        int n_any, n_pr, n_st;
        bit halt_inside;
        e_mask = 3'b111;
        if (reset_n && !squash && m_state == DC_RUN) begin
            best = 0;
            ok   = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                n_any = 0;
                n_pr  = 0;
                n_st  = 0;
                halt_inside = 1'b0;
                for (int s = 2; s >= 3 - k; s--) begin
                    if (req_valid[s]) begin
                        n_any++;
                        if (req_needs_pr[s]) n_pr++;
                        if (req_is_store[s]) n_st++;
                        if (req_is_halt[s] && s != 3 - k) halt_inside = 1'b1;
                    end
                end
                if (ok && n_any <= m_rob && n_any <= m_rs && n_pr <= m_pr &&
                    n_st <= m_sq && !halt_inside) best = k;
                else ok = 1'b0;
            end
            e_mask = 3'b111 >> best;
        end
        e_fire = req_valid & ~e_mask;
    endtask

    task automatic model_advance(input logic [2:0] f);
        if (!reset_n) begin
            m_rob = ROB_SIZE; m_rs = RS_SIZE; m_sq = SQ_SIZE; m_pr = PR_INIT;
            m_state = DC_RUN;
            m_known = 1'b1;
        end else if (m_known) begin
            if (squash) begin
                m_rob = ROB_SIZE; m_rs = RS_SIZE; m_sq = SQ_SIZE; m_pr = int'(fl_recover);
                m_state = DC_RECOVER;
            end else begin
                m_rob = m_rob + int'(rob_rel) - $countones(f);
                m_rs  = m_rs + int'(rs_rel) - $countones(f);
                m_sq  = m_sq + int'(sq_rel) - $countones(f & req_is_store);
                m_pr  = m_pr + int'(fl_rel) - $countones(f & req_needs_pr);
                case (m_state)
                    DC_RUN:     if (|(f & req_is_halt)) m_state = DC_HALT;
                    DC_RECOVER: m_state = DC_RUN;
                    default:    m_state = m_state;
                endcase
            end
        end
    endtask

    function automatic logic [1:0] pick_rel(input int room);
        int hi;
        hi = (room < 3) ? room : 3;
        return 2'($urandom_range(0, hi));
    endfunction

    vec_t tbl[13];
    vec_t seq[$];

    initial begin
        logic [2:0] e_mask, e_fire;

        reset_n = 1'b0; req_valid = '0; req_needs_pr = '0; req_is_store = '0; req_is_halt = '0;
        rob_rel = '0; rs_rel = '0; sq_rel = '0; fl_rel = '0; squash = 1'b0; fl_recover = '0;
        @(posedge clock);
        #1;

        // Reset row followed by scenarios 1-3 and a few boundary rows.
        tbl[0]  = '{1'b0, 3'b111, 3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 6'd5,
                    3'b111, 3'b000, 32, 16, 8, 32, DC_RUN};
        tbl[1]  = '{1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                    3'b000, 3'b111, 29, 13, 8, 29, DC_RUN};
        tbl[2]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                    3'b000, 3'b111, 26, 10, 8, 29, DC_RUN};
        tbl[3]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                    3'b000, 3'b111, 23, 7, 8, 29, DC_RUN};
        tbl[4]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                    3'b000, 3'b111, 20, 4, 8, 29, DC_RUN};
        tbl[5]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                    3'b000, 3'b111, 17, 1, 8, 29, DC_RUN};
        tbl[6]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                    3'b011, 3'b100, 16, 0, 8, 29, DC_RUN};
        tbl[7]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0, 6'd0,
                    3'b000, 3'b000, 16, 2, 8, 29, DC_RUN};
        tbl[8]  = '{1'b1, 3'b111, 3'b000, 3'b111, 3'b000, 2'd3, 2'd3, 2'd0, 2'd0, 1'b0, 6'd0,
                    3'b001, 3'b110, 17, 3, 6, 29, DC_RUN};
        tbl[9]  = '{1'b1, 3'b111, 3'b000, 3'b111, 3'b000, 2'd3, 2'd3, 2'd0, 2'd0, 1'b0, 6'd0,
                    3'b000, 3'b111, 17, 3, 3, 29, DC_RUN};
        tbl[10] = '{1'b1, 3'b011, 3'b000, 3'b011, 3'b000, 2'd3, 2'd3, 2'd0, 2'd0, 1'b0, 6'd0,
                    3'b000, 3'b011, 18, 4, 1, 29, DC_RUN};
        tbl[11] = '{1'b1, 3'b111, 3'b000, 3'b011, 3'b000, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 6'd0,
                    3'b001, 3'b110, 16, 2, 1, 29, DC_RUN};
        tbl[12] = '{1'b1, 3'b100, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd3, 1'b0, 6'd0,
                    3'b000, 3'b100, 15, 1, 1, 32, DC_RUN};
        for (int i = 0; i < 13; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

        // Invalid slot between a firing and a stalling slot.
        apply_vec('{1'b1, 3'b101, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                    3'b001, 3'b100, 14, 0, 1, 32, DC_RUN}, "gap");

        // Halt in slot 1, freeze, then wrong-path squash out of halt.
        seq.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                        3'b111, 3'b000, 32, 16, 8, 32, DC_RUN});
        seq.push_back('{1'b1, 3'b111, 3'b000, 3'b000, 3'b010, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                        3'b001, 3'b110, 30, 14, 8, 32, DC_HALT});
        seq.push_back('{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                        3'b111, 3'b000, 32, 14, 8, 32, DC_HALT});
        seq.push_back('{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                        3'b111, 3'b000, 32, 14, 8, 32, DC_HALT});
        seq.push_back('{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd0, 2'd0, 2'd0, 1'b1, 6'd10,
                        3'b111, 3'b000, 32, 16, 8, 10, DC_RECOVER});
        seq.push_back('{1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                        3'b111, 3'b000, 32, 16, 8, 10, DC_RUN});
        // Squash while dispatching, repeated squash holds recovery.
        seq.push_back('{1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                        3'b000, 3'b111, 29, 13, 8, 7, DC_RUN});
        seq.push_back('{1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 2'd1, 2'd1, 2'd0, 2'd1, 1'b1, 6'd20,
                        3'b111, 3'b000, 32, 16, 8, 20, DC_RECOVER});
        seq.push_back('{1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 6'd1,
                        3'b111, 3'b000, 32, 16, 8, 1, DC_RECOVER});
        seq.push_back('{1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                        3'b111, 3'b000, 32, 16, 8, 1, DC_RUN});
        // One free PR: slot 1 needs none, slot 0 is the second PR consumer.
        seq.push_back('{1'b1, 3'b111, 3'b101, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                        3'b001, 3'b110, 30, 14, 8, 0, DC_RUN});
        seq.push_back('{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                        3'b000, 3'b111, 27, 11, 8, 0, DC_RUN});
        // Reset beats a simultaneous squash.
        seq.push_back('{1'b0, 3'b111, 3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 6'd3,
                        3'b111, 3'b000, 32, 16, 8, 32, DC_RUN});
        seq.push_back('{1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0,
                        3'b000, 3'b111, 29, 13, 8, 29, DC_RUN});
        foreach (seq[i]) apply_vec(seq[i], $sformatf("seq%0d", i));

        // Randomized traffic against the model; releases never exceed outstanding entries.
        for (int n = 0; n < 3000; n++) begin
            reset_n      = (n == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
            req_valid    = 3'($urandom);
            req_needs_pr = 3'($urandom);
            req_is_store = 3'($urandom);
            for (int s = 0; s < 3; s++) req_is_halt[s] = ($urandom_range(0, 23) == 0);
            squash       = ($urandom_range(0, 15) == 0);
            fl_recover   = 6'($urandom_range(0, PR_INIT));
            rob_rel      = m_known ? pick_rel(ROB_SIZE - m_rob) : 2'd0;
            rs_rel       = m_known ? pick_rel(RS_SIZE - m_rs) : 2'd0;
            sq_rel       = m_known ? pick_rel(SQ_SIZE - m_sq) : 2'd0;
            fl_rel       = m_known ? pick_rel(PR_INIT - m_pr) : 2'd0;
            #4;
            model_outputs(e_mask, e_fire);
            check("rnd.mask", int'(stall_mask), int'(e_mask));
            check("rnd.fire", int'(fire), int'(e_fire));
            model_advance(e_fire);
            @(posedge clock);
            #1;
            check("rnd.rob", int'(rob_cr), m_rob);
            check("rnd.rs", int'(rs_cr), m_rs);
            check("rnd.sq", int'(sq_cr), m_sq);
            check("rnd.pr", int'(pr_cr), m_pr);
            check("rnd.state", int'(state), int'(m_state));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
